// File: rtl/med_spike_detect.sv
// Realigns the median stream with its raw sample via an internal FIFO and replaces
// samples whose distance from the median exceeds a threshold.
module med_spike_detect #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             dvi,
  input  logic [WIDTH-1:0] med,
  input  logic             dvo,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] y,
  output logic             spike,
  output logic             dvout,
  output logic [15:0]      nspike,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;
  logic [WIDTH-1:0] xr;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] d;
  logic             spike_c;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    // No bypass: an empty FIFO rejects the pop even if a push lands this cycle.
    pop_ok  = dvo && !empty;
    push_ok = dvi && (!full || pop_ok);
  end

  always_comb begin
    xr      = mem[rd_ptr];
    diff    = {1'b0, xr} - {1'b0, med};
    // Sign bit of the widened difference selects negation; magnitude always fits WIDTH.
    d       = diff[WIDTH] ? (~diff[WIDTH-1:0] + WIDTH'(1)) : diff[WIDTH-1:0];
    spike_c = (d > thresh);
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= x;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y      <= '0;
      spike  <= 1'b0;
      dvout  <= 1'b0;
      nspike <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      dvout <= pop_ok;
      if (pop_ok) begin
        y     <= spike_c ? med : xr;
        spike <= spike_c;
        if (spike_c && (nspike != 16'hFFFF)) begin
          nspike <= nspike + 16'd1;
        end
      end
      if (dvi && !push_ok) begin
        ovf <= 1'b1;
      end
      if (dvo && empty) begin
        unf <= 1'b1;
      end
    end
  end

endmodule
